// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern and selectable overlap.
// Optional saturating detection counter on det_count when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
    parameter int unsigned        PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1011,
    parameter int unsigned        CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seq_in,
    input  logic               seq_valid,
    input  logic               overlap_en,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               pat_load,
`ifdef SEQDET_COUNT_EN
    output logic [CNT_W-1:0]   det_count,
`endif
    output logic               det_out
);

    localparam int unsigned         FILL_W     = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL  = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0]   FILL_ARMED = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               det_q,  det_d;

    logic               sample;
    logic               match;
    logic [PAT_LEN-1:0] window;

    // seq_in is consumed only on edges with seq_valid=1 and no pattern load;
    // a load on the same edge discards the bit.
    always_comb begin
        sample = seq_valid & ~pat_load;
        window = {hist_q[PAT_LEN-2:0], seq_in};
        match  = sample && (fill_q >= FILL_ARMED) && (window == pat_q);
    end

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        det_d  = 1'b0;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (sample) begin
            hist_d = window;
            det_d  = match;
            // Non-overlap restarts the fill so the matched bits cannot be reused.
            if (match && !overlap_en) begin
                fill_d = '0;
            end else if (fill_q < FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q  <= RESET_PAT;
            hist_q <= '0;
            fill_q <= '0;
            det_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            det_q  <= det_d;
        end
    end

    assign det_out = det_q;

    logic unused_hist_msb;
    assign unused_hist_msb = hist_q[PAT_LEN-1];

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pat_load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign det_count = cnt_q;
`else
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = (CNT_W > 0);
`endif

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore-style serial pattern detector, the successor to the fixed 4-bit "1011" detector.
- Pattern length is a parameter; the pattern itself is runtime-loadable.
- Overlapping and non-overlapping detection are selectable at run time.
- Input bits are qualified by a valid strobe.
- Sits between a serial bit source and downstream control logic that consumes a one-cycle registered detect pulse.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..32.
RESET_PAT, 4'b1011, pattern register value after reset; PAT_LEN bits wide.
CNT_W, 8, width of det_count (used only with SEQDET_COUNT_EN).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
seq_in  input  1  serial data bit.
seq_valid  input  1  seq_in is sampled only on edges where this is 1.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
pat_in  input  PAT_LEN  new pattern value; bit PAT_LEN-1 is the first bit expected on the wire.
pat_load  input  1  loads pat_in into the pattern register.
det_out  output  1  registered detect pulse.
det_count  output  CNT_W  saturating detection count (only with SEQDET_COUNT_EN).

Behaviour:
- Reset state (reset=0, asynchronous):
  - pattern register = RESET_PAT
  - history register = 0
  - fill counter = 0
  - det_out = 0
  - det_count = 0
- History: PAT_LEN-bit shift register.
  - On each edge with seq_valid=1 and pat_load=0, it shifts left and seq_in enters the LSB.
  - With seq_valid=0, history and fill hold.
- Fill counter: counts valid bits since reset, load, or a non-overlap match. It saturates at PAT_LEN.
- Match condition, evaluated on a sampling edge:
  - fill (before the edge) >= PAT_LEN-1, and
  - {history[PAT_LEN-2:0], seq_in} == pattern.
- det_out:
  - Registered. It equals 1 for exactly one cycle, the cycle after the edge that samples the final pattern bit.
  - It is 0 in every other cycle, including cycles with seq_valid=0.
- Overlap mode (overlap_en=1): after a match, history and fill continue normally, so suffix bits count toward the next match.
- Non-overlap mode (overlap_en=0): on a match, fill is cleared to 0 on that same edge. History still shifts but is ignored until PAT_LEN new bits have arrived.
- overlap_en is sampled on every sampling edge. A change takes effect on the next sampled bit; there is no retroactive effect.
- pat_load=1 on an edge:
  - pattern <= pat_in
  - history <= 0
  - fill <= 0
  - det_out <= 0
- pat_load together with seq_valid: the load wins and the bit is discarded.
- Latency: sampled final bit to det_out high is 1 clock.
- Mid-operation reset: all state clears immediately and asynchronously, with no pulse emitted. Detection resumes only after PAT_LEN valid bits following reset release.
- Leading bits: no detection is possible until PAT_LEN valid bits have been received, even if the reset history of 0s would alias the pattern (e.g. pattern 0000).

Optional Feature:
Macro SEQDET_COUNT_EN.
- Defined:
  - det_count port exists.
  - It increments by 1 on every edge that sets det_out=1.
  - It saturates at 2^CNT_W-1.
  - It clears on reset and on pat_load.
- Undefined:
  - det_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Defaults, overlap_en=1, seq_valid=1, stream 1,0,1,1,0,1,1 at one bit per clock -> det_out pulses 1 cycle after the 4th and after the 7th bit; det_count=2 with SEQDET_COUNT_EN.
- Same stream, overlap_en=0 -> single pulse after the 4th bit only; det_count=1.
- Pattern 0000 after reset, four valid 0s with seq_valid toggled low between bits -> no pulse until the 4th valid 0; pulse exactly 1 cycle after it; no pulse while seq_valid=0.
- pat_load with pat_in=4'b0110 asserted together with seq_valid after bits 1,0 of a stream -> load takes effect and the simultaneous bit is discarded; the next valid bits 0,1,1,0 give a pulse after the 4th; the earlier bits must not contribute.
- reset driven low asynchronously mid-pattern (after 1,0,1) then released; then 1,0,1,1 -> no pulse from pre-reset bits; det_out is 0 immediately on reset; pulse after the new 4th bit.
- SEQDET_COUNT_EN with CNT_W=2, overlap stream producing 5 matches -> det_count reads 3 and holds; det_out still pulses 5 times.
